// File: rtl/cdc_handshake_tx_pkg.sv
// cdc_pkg
// Shared types and constants for the source side of the toggle-handshake
// clock-domain crossing.
//   cdc_tx_state_t     : IDLE (ready for a word) / WAIT_ACK (word in flight)
//   CDC_MIN_SYNC_DEPTH : smallest legal ack synchronizer depth
package cdc_pkg;

    typedef enum logic {IDLE, WAIT_ACK} cdc_tx_state_t;

    localparam int CDC_MIN_SYNC_DEPTH = 2;

endpackage

// File: rtl/cdc_handshake_tx_if.sv
// cdc_handshake_tx_if
// Bundles the upstream valid/ready word interface and the two-phase req/ack
// crossing signals of cdc_handshake_tx.
//   valid_i, data_i : upstream word offer
//   ready_o         : block accepts a word this cycle
//   data_o          : word held stable for the destination domain
//   req_o           : request toggle to the destination
//   ack_i           : acknowledge toggle from the destination (asynchronous)
//   busy_o          : transfer in flight
// slave modport is the block itself; master modport is its environment.
interface cdc_handshake_tx_if #(
    parameter int WIDTH = 8
);

    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data_i;
    logic [WIDTH-1:0] data_o;
    logic             req_o;
    logic             ack_i;
    logic             busy_o;

    modport slave (
        input  valid_i, data_i, ack_i,
        output ready_o, data_o, req_o, busy_o
    );

    modport master (
        output valid_i, data_i, ack_i,
        input  ready_o, data_o, req_o, busy_o
    );

endinterface

// File: rtl/cdc_handshake_tx_toggle_sync.sv
// cdc_toggle_sync
// Multi-flop synchronizer bringing the destination's ack toggle into the
// source clock domain. All flops reset to 0 together with the source side.
//   clk     : source-domain clock
//   rst     : asynchronous, active-high reset
//   d_async : asynchronous toggle input
//   q       : synchronized level (last stage of the chain)
module cdc_toggle_sync
    import cdc_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic q
);

    // A chain shorter than two flops gives no real metastability margin.
    if (DEPTH < CDC_MIN_SYNC_DEPTH) begin : g_depth_check
        $error("cdc_toggle_sync: DEPTH below CDC_MIN_SYNC_DEPTH");
    end

    // Keep attribute stops synthesis from merging or retiming the chain,
    // which would defeat its purpose as a metastability filter.
    (* keep = "true" *) logic [DEPTH-1:0] chain;

    // Shift the asynchronous level through the chain, oldest at the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[DEPTH-2:0], d_async};
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx
// Sending end of a two-phase (toggle) req/ack multi-bit clock-domain
// crossing. A word accepted on valid/ready is registered onto data_o and
// req_o flips; the block then waits until the synchronized ack toggle
// matches req_o before accepting the next transfer.
//   clk, rst : source clock, asynchronous active-high reset
//   bus      : cdc_handshake_tx_if.slave (valid_i, ready_o, data_i, data_o,
//              req_o, ack_i, busy_o)
// Optional build macro CDC_HANDSHAKE_TX_SKID_EN adds a one-entry skid
// register so a second word can be accepted while a transfer is in flight.
module cdc_handshake_tx
    import cdc_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SYNC_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    cdc_handshake_tx_if.slave     bus
);

    cdc_tx_state_t    state;
    cdc_tx_state_t    state_next;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_next;
    logic             req_q;
    logic             req_next;
    logic             ack_sync;
    logic             ready;
    logic             accept;
    logic             done;

`ifdef CDC_HANDSHAKE_TX_SKID_EN
    logic [WIDTH-1:0] skid_data;
    logic [WIDTH-1:0] skid_data_next;
    logic             skid_full;
    logic             skid_full_next;
`endif

    // ack_i only ever reaches the control logic through this chain, so no
    // output has a combinational path from the other clock domain.
    cdc_toggle_sync #(
        .DEPTH   (SYNC_DEPTH)
    ) u_ack_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async (bus.ack_i),
        .q       (ack_sync)
    );

    // State and the launched word/request. Reset drops any in-flight word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            data_q <= '0;
            req_q  <= 1'b0;
        end else begin
            state  <= state_next;
            data_q <= data_next;
            req_q  <= req_next;
        end
    end

`ifdef CDC_HANDSHAKE_TX_SKID_EN
    // Skid register holding one word accepted while a transfer is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_data <= '0;
            skid_full <= 1'b0;
        end else begin
            skid_data <= skid_data_next;
            skid_full <= skid_full_next;
        end
    end
`endif

    // Next-state logic. A transfer completes once the synchronized ack has
    // caught up with req_q; a mismatching ack while idle is simply ignored.
    always_comb begin
        state_next = state;
        data_next  = data_q;
        req_next   = req_q;
`ifdef CDC_HANDSHAKE_TX_SKID_EN
        skid_data_next = skid_data;
        skid_full_next = skid_full;
        ready          = (state == IDLE) || !skid_full;
`else
        ready          = (state == IDLE);
`endif
        accept = bus.valid_i && ready;
        done   = (state == WAIT_ACK) && (ack_sync == req_q);

        case (state)
            IDLE: begin
                if (accept) begin
                    data_next  = bus.data_i;
                    req_next   = ~req_q;
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
`ifdef CDC_HANDSHAKE_TX_SKID_EN
                // On completion the next word (skid first, otherwise one
                // offered this very cycle) launches without visiting IDLE.
                if (done) begin
                    if (skid_full) begin
                        data_next      = skid_data;
                        req_next       = ~req_q;
                        skid_full_next = 1'b0;
                    end else if (accept) begin
                        data_next = bus.data_i;
                        req_next  = ~req_q;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (accept) begin
                    skid_data_next = bus.data_i;
                    skid_full_next = 1'b1;
                end
`else
                if (done) begin
                    state_next = IDLE;
                end
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.ready_o = ready;
    assign bus.busy_o  = (state == WAIT_ACK);
    assign bus.data_o  = data_q;
    assign bus.req_o   = req_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx
// Self-checking bench for cdc_handshake_tx (WIDTH=8, SYNC_DEPTH=3). A
// transaction-level reference model predicts ready/busy/req/data every
// cycle, and a destination model returns ack toggles and records the words
// it sees so delivery order can be compared with acceptance order.
// Honours CDC_HANDSHAKE_TX_SKID_EN when defined for the whole build.
module tb_cdc_handshake_tx;

    localparam int WIDTH      = 8;
    localparam int SYNC_DEPTH = 3;

    logic clk;
    logic rst;

    cdc_handshake_tx_if #(.WIDTH(WIDTH)) bus ();

    cdc_handshake_tx #(
        .WIDTH      (WIDTH),
        .SYNC_DEPTH (SYNC_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Reference model state: what the sender should be doing, in terms of
    // "is a word in flight, which word, which request level".
    bit               m_busy;
    bit               m_req;
    logic [WIDTH-1:0] m_data;
    bit               m_skid_full;
    logic [WIDTH-1:0] m_skid_data;
    bit               ack_hist[$];
    logic [WIDTH-1:0] sent_q[$];
    logic [WIDTH-1:0] rx_q[$];

    // Destination model state.
    bit dst_enable;
    bit dst_ack;
    int dst_delay;
    bit man_ack;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit modelReady();
`ifdef CDC_HANDSHAKE_TX_SKID_EN
        return !m_busy || !m_skid_full;
`else
        return !m_busy;
`endif
    endfunction

    task automatic modelReset();
        m_busy      = 0;
        m_req       = 0;
        m_data      = '0;
        m_skid_full = 0;
        m_skid_data = '0;
        ack_hist.delete();
        sent_q.delete();
        rx_q.delete();
        dst_ack   = 0;
        dst_delay = -1;
    endtask

    // Advance the model across one clock edge. The ack level seen by the
    // control logic at edge e is the ack_i driven SYNC_DEPTH edges earlier.
    task automatic modelStep(input bit v, input logic [WIDTH-1:0] d, input bit a);
        int idx;
        bit seen_ack;
        bit acc;
        ack_hist.push_back(a);
        idx      = ack_hist.size() - 1 - SYNC_DEPTH;
        seen_ack = (idx >= 0) ? ack_hist[idx] : 1'b0;
        acc      = v && modelReady();
        if (acc) sent_q.push_back(d);
        if (!m_busy) begin
            if (acc) begin
                m_data = d;
                m_req  = !m_req;
                m_busy = 1;
            end
        end else if (seen_ack == m_req) begin
            if (m_skid_full) begin
                m_data      = m_skid_data;
                m_req       = !m_req;
                m_skid_full = 0;
            end else if (acc) begin
                m_data = d;
                m_req  = !m_req;
            end else begin
                m_busy = 0;
            end
        end else if (acc) begin
            m_skid_data = d;
            m_skid_full = 1;
        end
    endtask

    // Destination: notices a new request level, waits a little, captures
    // data_o and toggles ack to match.
    task automatic destStep();
        if (dst_enable) begin
            if (dst_delay < 0 && bus.req_o != dst_ack) dst_delay = $urandom_range(0, 3);
            if (dst_delay == 0) begin
                rx_q.push_back(bus.data_o);
                dst_ack   = !dst_ack;
                dst_delay = -1;
            end else if (dst_delay > 0) begin
                dst_delay--;
            end
            bus.ack_i = dst_ack;
        end else begin
            bus.ack_i = man_ack;
        end
    endtask

    task automatic compareModel();
        checkOutput("ready", {31'd0, bus.ready_o}, {31'd0, modelReady()});
        checkOutput("busy",  {31'd0, bus.busy_o},  {31'd0, m_busy});
        checkOutput("req",   {31'd0, bus.req_o},   {31'd0, m_req});
        checkOutput("data",  {24'd0, bus.data_o},  {24'd0, m_data});
    endtask

    // One cycle: drive at the falling edge, step the model, clock, then
    // compare at the next falling edge.
    task automatic applyStimulus(input bit v, input logic [WIDTH-1:0] d);
        bus.valid_i = v;
        bus.data_i  = d;
        destStep();
        modelStep(v, d, bus.ack_i);
        @(posedge clk);
        @(negedge clk);
        compareModel();
    endtask

    task automatic sendWord(input logic [WIDTH-1:0] d);
        bit acc;
        bit got_in;
        got_in = 0;
        for (int i = 0; i < 200 && !got_in; i++) begin
            acc = modelReady();
            applyStimulus(1'b1, d);
            if (acc) got_in = 1;
        end
        checkOutput("send_timeout", {31'd0, got_in}, 32'd1);
        bus.valid_i = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (!m_busy && (!dst_enable || (dst_delay < 0 && bus.req_o == dst_ack))) break;
            applyStimulus(1'b0, '0);
        end
        checkOutput("drain_timeout", {31'd0, m_busy}, 32'd0);
    endtask

    task automatic compareDelivered();
        checkOutput("rx_count", rx_q.size(), sent_q.size());
        for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++) begin
            checkOutput("rx_word", {24'd0, rx_q[i]}, {24'd0, sent_q[i]});
        end
        rx_q.delete();
        sent_q.delete();
    endtask

    task automatic doReset();
        rst         = 1'b1;
        man_ack     = 1'b0;
        bus.ack_i   = 1'b0;
        bus.valid_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        logic [WIDTH-1:0] word;
        logic [WIDTH-1:0] held;
        bit have_word;
        bit acc;

        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.ack_i   = 1'b0;
        dst_enable  = 0;
        man_ack     = 0;
        modelReset();

        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", {31'd0, bus.ready_o}, 32'd1);
        checkOutput("rst_busy",  {31'd0, bus.busy_o},  32'd0);
        checkOutput("rst_req",   {31'd0, bus.req_o},   32'd0);
        checkOutput("rst_data",  {24'd0, bus.data_o},  32'd0);
        rst = 1'b0;
        modelReset();

        // Single word with a hand-driven ack: completion exactly four edges
        // after the ack toggle is presented.
        applyStimulus(1'b1, 8'hA5);
        checkOutput("a5_data", {24'd0, bus.data_o}, 32'hA5);
        checkOutput("a5_req",  {31'd0, bus.req_o},  32'd1);
        checkOutput("a5_busy", {31'd0, bus.busy_o}, 32'd1);
        repeat (5) applyStimulus(1'b0, '0);
        man_ack = 1'b1;
        repeat (3) applyStimulus(1'b0, '0);
        checkOutput("a5_busy_hold", {31'd0, bus.busy_o}, 32'd1);
        applyStimulus(1'b0, '0);
        checkOutput("a5_busy_done", {31'd0, bus.busy_o}, 32'd0);
        checkOutput("a5_ready_done", {31'd0, bus.ready_o}, 32'd1);

        // Back-to-back words through the destination model.
        doReset();
        dst_enable = 1;
        sendWord(8'h11);
`ifndef CDC_HANDSHAKE_TX_SKID_EN
        checkOutput("b2b_req1", {31'd0, bus.req_o}, 32'd1);
`endif
        sendWord(8'h22);
`ifndef CDC_HANDSHAKE_TX_SKID_EN
        checkOutput("b2b_req2", {31'd0, bus.req_o}, 32'd0);
`endif
        sendWord(8'h33);
`ifndef CDC_HANDSHAKE_TX_SKID_EN
        checkOutput("b2b_req3", {31'd0, bus.req_o}, 32'd1);
`endif
        drain();
        compareDelivered();

        // Backpressure: 0x3C offered continuously while 0x5A is in flight.
        sendWord(8'h5A);
        repeat (3) applyStimulus(1'b1, 8'h3C);
        sendWord(8'h3C);
        drain();
        compareDelivered();

        // Randomized traffic; upstream holds its word until accepted.
        have_word = 0;
        word      = '0;
        for (int i = 0; i < 300; i++) begin
            if (!have_word && ($urandom_range(0, 1) == 1)) begin
                have_word = 1;
                word      = WIDTH'($urandom);
            end
            acc = have_word && modelReady();
            applyStimulus(have_word, word);
            if (acc) have_word = 0;
        end
        bus.valid_i = 1'b0;
        drain();
        compareDelivered();

        // Stale ack while idle: nothing may move.
        dst_enable = 0;
        man_ack    = !m_req;
        held       = bus.data_o;
        repeat (6) applyStimulus(1'b0, '0);
        checkOutput("stale_busy", {31'd0, bus.busy_o}, 32'd0);
        checkOutput("stale_data", {24'd0, bus.data_o}, {24'd0, held});

        // Reset asserted between edges mid-transfer.
        doReset();
        applyStimulus(1'b1, 8'h7E);
        applyStimulus(1'b0, '0);
        applyStimulus(1'b0, '0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_req",   {31'd0, bus.req_o},   32'd0);
        checkOutput("midrst_data",  {24'd0, bus.data_o},  32'd0);
        checkOutput("midrst_busy",  {31'd0, bus.busy_o},  32'd0);
        checkOutput("midrst_ready", {31'd0, bus.ready_o}, 32'd1);
        man_ack   = 1'b0;
        bus.ack_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        dst_enable = 1;
        sendWord(8'h01);
        drain();
        checkOutput("post_rst_count", rx_q.size(), 32'd1);
        compareDelivered();

`ifdef CDC_HANDSHAKE_TX_SKID_EN
        // Skid: second word launches on the completion edge of the first.
        doReset();
        dst_enable = 0;
        sendWord(8'h44);
        sendWord(8'h55);
        checkOutput("skid_full_ready", {31'd0, bus.ready_o}, 32'd0);
        man_ack = 1'b1;
        repeat (4) applyStimulus(1'b0, '0);
        checkOutput("skid_data",  {24'd0, bus.data_o},  32'h55);
        checkOutput("skid_busy",  {31'd0, bus.busy_o},  32'd1);
        checkOutput("skid_req",   {31'd0, bus.req_o},   32'd0);
        checkOutput("skid_ready", {31'd0, bus.ready_o}, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
